sram_arbiter: RTL and testbench

// Two-port arbiter and access sequencer for the 8-bit asynchronous SRAM macro.

---
 rtl/sram_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-requester arbiter and strobe sequencer for a shared asynchronous SRAM.
// Each access takes four cycles (IDLE, SETUP, STROBE, FINISH) and every output is registered.
module sram_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int PRIO_RR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          busy,
    output logic          sram_cs,
    output logic          sram_wr,
    output logic          sram_rd,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, FINISH} state_t;

    state_t        state, state_nxt;
    logic          sel, sel_nxt;       // granted requester: 0 = A, 1 = B
    logic          we_l, we_nxt;
    logic          rr_ptr, rr_nxt;     // requester favoured on the next conflict
    logic          grant_b;
    logic          busy_nxt;
    logic          cs_nxt, wr_nxt, rd_nxt;
    logic          a_ack_nxt, b_ack_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] din_nxt;
    logic [DW-1:0] a_rdata_nxt, b_rdata_nxt;

    always_comb begin
        grant_b = b_req && (!a_req || ((PRIO_RR != 0) && rr_ptr));
    end

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        we_nxt      = we_l;
        rr_nxt      = rr_ptr;
        cs_nxt      = 1'b0;
        wr_nxt      = 1'b0;
        rd_nxt      = 1'b1;
        addr_nxt    = sram_addr;
        din_nxt     = sram_din;
        a_ack_nxt   = 1'b0;
        b_ack_nxt   = 1'b0;
        a_rdata_nxt = a_rdata;
        b_rdata_nxt = b_rdata;

        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    // The SRAM address/data registers double as the request latch.
                    sel_nxt   = grant_b;
                    we_nxt    = grant_b ? b_we    : a_we;
                    addr_nxt  = grant_b ? b_addr  : a_addr;
                    din_nxt   = grant_b ? b_wdata : a_wdata;
                    rr_nxt    = ~rr_ptr;
                    cs_nxt    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cs_nxt    = 1'b1;
                wr_nxt    = we_l;
                rd_nxt    = we_l;
                state_nxt = STROBE;
            end
            STROBE: begin
                // Leaving STROBE: read data is valid on sram_dout right now.
                a_ack_nxt = ~sel;
                b_ack_nxt = sel;
                if (!we_l) begin
                    if (sel) begin
                        b_rdata_nxt = sram_dout;
                    end else begin
                        a_rdata_nxt = sram_dout;
                    end
                end
                state_nxt = FINISH;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 1'b0;
            we_l      <= 1'b0;
            rr_ptr    <= 1'b0;
            busy      <= 1'b0;
            sram_cs   <= 1'b0;
            sram_wr   <= 1'b0;
            sram_rd   <= 1'b1;
            sram_addr <= '0;
            sram_din  <= '0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            we_l      <= we_nxt;
            rr_ptr    <= rr_nxt;
            busy      <= busy_nxt;
            sram_cs   <= cs_nxt;
            sram_wr   <= wr_nxt;
            sram_rd   <= rd_nxt;
            sram_addr <= addr_nxt;
            sram_din  <= din_nxt;
            a_ack     <= a_ack_nxt;
            b_ack     <= b_ack_nxt;
            a_rdata   <= a_rdata_nxt;
            b_rdata   <= b_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a round-robin instance with an SRAM model and a memory/arbitration
// reference model, plus a fixed-priority instance used for the held-request ordering check.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [7:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic       a_ack, b_ack, busy, sram_cs, sram_wr, sram_rd;
    logic [7:0] a_rdata, b_rdata, sram_addr, sram_din, sram_dout;

    logic       f_a_req = 1'b0, f_b_req = 1'b0;
    logic       f_a_ack, f_b_ack, f_busy, f_cs, f_wr, f_rd;
    logic [7:0] f_a_rdata, f_b_rdata, f_addr, f_din, f_dout;

    logic [7:0] mem     [256];
    logic [7:0] f_mem   [256];
    logic [7:0] ref_mem [256];
    logic [7:0] exp_rdata [2];
    bit         rr;
    int         total = 0;
    int         bad = 0;

    sram_arbiter #(.AW(8), .DW(8), .PRIO_RR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .busy(busy), .sram_cs(sram_cs), .sram_wr(sram_wr), .sram_rd(sram_rd),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    sram_arbiter #(.AW(8), .DW(8), .PRIO_RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_req(f_a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(f_a_ack), .a_rdata(f_a_rdata),
        .b_req(f_b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(f_b_ack), .b_rdata(f_b_rdata),
        .busy(f_busy), .sram_cs(f_cs), .sram_wr(f_wr), .sram_rd(f_rd),
        .sram_addr(f_addr), .sram_din(f_din), .sram_dout(f_dout)
    );

    // Asynchronous SRAM models: write on wr rising edge, read data only while selected and rd low.
    assign sram_dout = (sram_cs && !sram_rd) ? mem[sram_addr] : 8'hEE;
    always @(posedge sram_wr) if (sram_cs) mem[sram_addr] <= sram_din;
    assign f_dout = (f_cs && !f_rd) ? f_mem[f_addr] : 8'hEE;
    always @(posedge f_wr) if (f_cs) f_mem[f_addr] <= f_din;

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ((sram_wr && !sram_rd) || (!sram_cs && (sram_wr || !sram_rd))) begin
                bad++;
                $display("FAIL strobe_rules cs=%0b wr=%0b rd=%0b required no wr/rd overlap and strobes only with cs",
                         sram_cs, sram_wr, sram_rd);
            end
            total++;
            if ((f_wr && !f_rd) || (!f_cs && (f_wr || !f_rd))) begin
                bad++;
                $display("FAIL fp_strobe_rules cs=%0b wr=%0b rd=%0b required no wr/rd overlap and strobes only with cs",
                         f_cs, f_wr, f_rd);
            end
        end
    end

    // Reference model: one completed access in grant order.
    function automatic void model_op(input bit p, input bit we, input logic [7:0] addr, input logic [7:0] data);
        if (we) ref_mem[addr] = data;
        else    exp_rdata[p] = ref_mem[addr];
        rr = ~rr;
    endfunction

    function automatic logic ack_of(input bit p);
        return p ? b_ack : a_ack;
    endfunction

    task automatic drive(input bit p, input bit req, input bit we, input logic [7:0] addr, input logic [7:0] data);
        if (p) begin b_req = req; b_we = we; b_addr = addr; b_wdata = data; end
        else   begin a_req = req; a_we = we; a_addr = addr; a_wdata = data; end
    endtask

    task automatic do_single(input bit p, input bit we, input logic [7:0] addr, input logic [7:0] data);
        int ackat = -1, ackc = 0, otherc = 0, wrc = 0, rdc = 0;
        @(negedge clk);
        drive(p, 1'b1, we, addr, data);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (sram_wr) wrc++;
            if (!sram_rd) rdc++;
            if (ack_of(!p)) otherc++;
            if (ack_of(p)) begin
                ackc++;
                if (ackat < 0) ackat = i;
                drive(p, 1'b0, we, addr, data);
            end
            if (i == 1) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b required=1", busy); end
            end
            if (i == 5) begin
                total++;
                if (busy !== 1'b0) begin bad++; $display("FAIL single_idle busy got=%0b required=0", busy); end
            end
        end
        model_op(p, we, addr, data);
        total++;
        if (ackat != 3 || ackc != 1 || otherc != 0) begin
            bad++;
            $display("FAIL single_ack p=%0d ack_edge=%0d acks=%0d other_acks=%0d required edge 3, 1 ack, 0 other",
                     p, ackat, ackc, otherc);
        end
        total++;
        if (wrc != (we ? 1 : 0) || rdc != (we ? 0 : 1)) begin
            bad++;
            $display("FAIL single_strobes we=%0b wr_cycles=%0d rd_cycles=%0d required %0d/%0d",
                     we, wrc, rdc, we ? 1 : 0, we ? 0 : 1);
        end
        total++;
        if (a_rdata !== exp_rdata[0] || b_rdata !== exp_rdata[1]) begin
            bad++;
            $display("FAIL single_rdata a=%h b=%h required a=%h b=%h", a_rdata, b_rdata, exp_rdata[0], exp_rdata[1]);
        end
    endtask

    task automatic do_pair(input bit wa, input logic [7:0] aa, input logic [7:0] da,
                           input bit wb, input logic [7:0] ab, input logic [7:0] db);
        int at [2];
        int ac [2];
        bit w;
        at[0] = -1; at[1] = -1; ac[0] = 0; ac[1] = 0;
        w = rr;
        @(negedge clk);
        drive(1'b0, 1'b1, wa, aa, da);
        drive(1'b1, 1'b1, wb, ab, db);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (a_ack) begin ac[0]++; if (at[0] < 0) at[0] = i; a_req = 1'b0; end
            if (b_ack) begin ac[1]++; if (at[1] < 0) at[1] = i; b_req = 1'b0; end
        end
        if (w) begin model_op(1'b1, wb, ab, db); model_op(1'b0, wa, aa, da); end
        else   begin model_op(1'b0, wa, aa, da); model_op(1'b1, wb, ab, db); end
        total++;
        if (at[w ? 1 : 0] != 3 || at[w ? 0 : 1] != 7 || ac[0] != 1 || ac[1] != 1) begin
            bad++;
            $display("FAIL pair_order a_edge=%0d b_edge=%0d acks=%0d/%0d required winner=%0d at 3, loser at 7",
                     at[0], at[1], ac[0], ac[1], w);
        end
        total++;
        if (a_rdata !== exp_rdata[0] || b_rdata !== exp_rdata[1]) begin
            bad++;
            $display("FAIL pair_rdata a=%h b=%h required a=%h b=%h", a_rdata, b_rdata, exp_rdata[0], exp_rdata[1]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({sram_cs, sram_wr, sram_rd, busy, a_ack, b_ack} !== 6'b001000) begin
            bad++;
            $display("FAIL reset_ctrl cs/wr/rd/busy/aack/back=%b required 001000",
                     {sram_cs, sram_wr, sram_rd, busy, a_ack, b_ack});
        end
        total++;
        if ({sram_addr, sram_din, a_rdata, b_rdata} !== 32'h0) begin
            bad++;
            $display("FAIL reset_data addr=%h din=%h ardata=%h brdata=%h required all 0",
                     sram_addr, sram_din, a_rdata, b_rdata);
        end
        total++;
        if ({f_cs, f_wr, f_rd, f_busy, f_a_ack, f_b_ack} !== 6'b001000 ||
            {f_addr, f_din, f_a_rdata, f_b_rdata} !== 32'h0) begin
            bad++;
            $display("FAIL reset_fp ctrl=%b data=%h required 001000 and 0",
                     {f_cs, f_wr, f_rd, f_busy, f_a_ack, f_b_ack}, {f_addr, f_din, f_a_rdata, f_b_rdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        rr = 1'b0;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || sram_cs !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%0b cs=%0b required 0/0 with no requests", busy, sram_cs);
        end
    endtask

    task automatic test_basic;
        do_single(1'b0, 1'b1, 8'h10, 8'h3C);
        do_single(1'b0, 1'b0, 8'h10, 8'h00);
        total++;
        if (a_rdata !== 8'h3C) begin bad++; $display("FAIL basic_readback got=%h required=3c", a_rdata); end
        do_single(1'b1, 1'b1, 8'h20, 8'h5A);
        do_single(1'b1, 1'b0, 8'h20, 8'h00);
        total++;
        if (a_rdata !== 8'h3C || b_rdata !== 8'h5A) begin
            bad++;
            $display("FAIL basic_b_read a=%h b=%h required a=3c b=5a", a_rdata, b_rdata);
        end
    endtask

    task automatic test_conflict;
        do_pair(1'b1, 8'h01, 8'h55, 1'b1, 8'h02, 8'hAA);
        do_single(1'b0, 1'b0, 8'h01, 8'h00);
        do_single(1'b1, 1'b0, 8'h02, 8'h00);
        total++;
        if (a_rdata !== 8'h55 || b_rdata !== 8'hAA) begin
            bad++;
            $display("FAIL conflict_readback a=%h b=%h required a=55 b=aa", a_rdata, b_rdata);
        end
    endtask

    task automatic test_boundary;
        do_single(1'b0, 1'b1, 8'hFF, 8'hFF);
        do_single(1'b1, 1'b1, 8'h00, 8'h00);
        do_single(1'b0, 1'b0, 8'hFF, 8'h00);
        do_single(1'b1, 1'b0, 8'h00, 8'h00);
        total++;
        if (a_rdata !== 8'hFF || b_rdata !== 8'h00) begin
            bad++;
            $display("FAIL boundary a=%h b=%h required a=ff b=00", a_rdata, b_rdata);
        end
    endtask

    task automatic test_held;
        int nr = 0, nf = 0;
        bit ew;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
        f_a_req = 1'b1;
        f_b_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (a_ack || b_ack) begin
                ew = rr;
                total++;
                if ((ew ? b_ack : a_ack) !== 1'b1 || (a_ack && b_ack) || i != 4 * nr + 3) begin
                    bad++;
                    $display("FAIL held_rr n=%0d edge=%0d a_ack=%0b b_ack=%0b required %s at edge %0d",
                             nr, i, a_ack, b_ack, ew ? "B" : "A", 4 * nr + 3);
                end
                model_op(ew, 1'b0, ew ? 8'h20 : 8'h10, 8'h00);
                nr++;
                if (nr == 4) begin a_req = 1'b0; b_req = 1'b0; end
            end
            if (f_a_ack || f_b_ack) begin
                total++;
                if (f_b_ack !== 1'b0 || i != 4 * nf + 3) begin
                    bad++;
                    $display("FAIL held_fixed n=%0d edge=%0d a_ack=%0b b_ack=%0b required A at edge %0d",
                             nf, i, f_a_ack, f_b_ack, 4 * nf + 3);
                end
                nf++;
                if (nf == 4) begin f_a_req = 1'b0; f_b_req = 1'b0; end
            end
        end
        total++;
        if (nr != 4 || nf != 4 || a_rdata !== exp_rdata[0] || b_rdata !== exp_rdata[1]) begin
            bad++;
            $display("FAIL held_count rr=%0d fixed=%0d a=%h b=%h required 4/4 a=%h b=%h",
                     nr, nf, a_rdata, b_rdata, exp_rdata[0], exp_rdata[1]);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 16; k++) do_single(k[0], 1'b1, 8'h80 + 8'(k), 8'($urandom));
        for (int k = 0; k < 24; k++)
            do_single(1'($urandom), 1'($urandom), 8'h80 + 8'($urandom_range(0, 15)), 8'($urandom));
        for (int k = 0; k < 12; k++)
            do_pair(1'($urandom), 8'h80 + 8'($urandom_range(0, 15)), 8'($urandom),
                    1'($urandom), 8'h80 + 8'($urandom_range(0, 15)), 8'($urandom));
    endtask

    task automatic test_reset_mid;
        int stray = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (sram_rd !== 1'b0) begin bad++; $display("FAIL midreset_strobe rd=%0b required 0", sram_rd); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({sram_cs, sram_wr, sram_rd, busy, a_ack, b_ack} !== 6'b001000 ||
            {sram_addr, sram_din, a_rdata, b_rdata} !== 32'h0) begin
            bad++;
            $display("FAIL midreset_values ctrl=%b data=%h required 001000 and 0",
                     {sram_cs, sram_wr, sram_rd, busy, a_ack, b_ack}, {sram_addr, sram_din, a_rdata, b_rdata});
        end
        a_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rr = 1'b0;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (a_ack || b_ack || busy) stray++;
        end
        total++;
        if (stray != 0) begin bad++; $display("FAIL midreset_noack stray_cycles=%0d required 0", stray); end
        do_single(1'b0, 1'b0, 8'h01, 8'h00);
        total++;
        if (a_rdata !== 8'h55) begin bad++; $display("FAIL midreset_after got=%h required=55", a_rdata); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_conflict();
        test_boundary();
        test_held();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
